// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage between the control path and a combinational program ROM.
//   Owns the program counter, drives the ROM address straight from it, and
//   registers the returned instruction (with its fetch address) for decode.
//   A taken branch redirects the PC and inserts exactly one bubble.
//   Stall freezes all state.
//
// Optional feature: define FETCH_PERF_COUNT_EN to build a saturating count of
//   valid instructions delivered. Without it, oFetchCount is tied to zero.
//
// Ports:
//   Clock             in   system clock, all state on the rising edge
//   Reset             in   synchronous, active-high
//   oAddress          out  ROM address (the PC), combinational from the PC register
//   iRomInstruction   in   ROM data for oAddress, same cycle
//   oInstruction      out  instruction register
//   oInstructionValid out  oInstruction is a real fetch, not a bubble
//   oPC               out  address oInstruction was fetched from
//   iStall            in   decode back-pressure; hold everything
//   iBranchTaken      in   one-cycle redirect request from execute
//   iBranchTarget     in   redirect target, qualified by iBranchTaken
//   oFetchCount       out  valid instructions delivered (0 unless enabled)

`ifndef NOP
`define NOP 4'h0
`endif

module instruction_fetch #(
  parameter int unsigned           ADDR_W   = 16,
  parameter int unsigned           INSTR_W  = 28,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  oAddress,
  input  logic [INSTR_W-1:0] iRomInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oInstructionValid,
  output logic [ADDR_W-1:0]  oPC,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [15:0]        oFetchCount
);

  localparam logic [INSTR_W-1:0] NopInstr = {`NOP, {(INSTR_W-4){1'b0}}};

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               valid_q, valid_d;
  logic               load;

  // Next-state: branch beats stall, stall beats a normal advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    load    = 1'b0;

    if (iBranchTaken) begin
      pc_d    = iBranchTarget;
      ir_d    = NopInstr;
      valid_d = 1'b0;
      state_d = StFlush;
    end else if (!iStall) begin
      load    = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
      ir_d    = iRomInstruction;
      ir_pc_d = pc_q;
      valid_d = 1'b1;
      // Boot and flush both fetch exactly like run; they differ only in
      // what IR held while waiting.
      unique case (state_q)
        StBoot:  state_d = StRun;
        StRun:   state_d = StRun;
        StFlush: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      ir_q    <= NopInstr;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
    end
  end

  assign oAddress          = pc_q;
  assign oInstruction      = ir_q;
  assign oInstructionValid = valid_q;
  assign oPC               = ir_pc_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_count_q <= '0;
    end else if (load && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign oFetchCount = fetch_count_q;
`else
  logic unused_load;
  assign unused_load = load;
  assign oFetchCount = 16'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iRomInstruction;
  logic [27:0] oInstruction;
  logic        oInstructionValid;
  logic [15:0] oPC;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [15:0] oFetchCount;

  localparam logic [27:0] NopInstr = 28'h0000000;

  int          passed  = 0;
  int          total   = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 Clock = ~Clock;

  instruction_fetch dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .oAddress          (oAddress),
    .iRomInstruction   (iRomInstruction),
    .oInstruction      (oInstruction),
    .oInstructionValid (oInstructionValid),
    .oPC               (oPC),
    .iStall            (iStall),
    .iBranchTaken      (iBranchTaken),
    .iBranchTarget     (iBranchTarget),
    .oFetchCount       (oFetchCount)
  );

  // ROM: a tagged copy of the address, so real fetches never look like a bubble.
  function automatic logic [27:0] rom(input logic [15:0] a);
    return {4'h5, 8'h00, a};
  endfunction

  assign iRomInstruction = rom(oAddress);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: apply inputs, take the edge, check the counter on the falling edge.
  task automatic cyc(input logic rst, input logic br, input logic [15:0] tgt, input logic st);
    Reset         = rst;
    iBranchTaken  = br;
    iBranchTarget = tgt;
    iStall        = st;
    @(posedge Clock);
    if (rst) exp_cnt = 16'd0;
    else if (!br && !st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(negedge Clock);
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_count", {16'd0, oFetchCount}, {16'd0, exp_cnt});
`else
    chk("fetch_count", {16'd0, oFetchCount}, 32'd0);
`endif
  endtask

  task automatic expect_valid(input string tag, input logic [15:0] pc);
    logic [15:0] nxt;
    nxt = pc + 16'd1;
    chk({tag, "_valid"}, {31'd0, oInstructionValid}, 32'd1);
    chk({tag, "_pc"},    {16'd0, oPC},               {16'd0, pc});
    chk({tag, "_instr"}, {4'd0, oInstruction},       {4'd0, rom(pc)});
    chk({tag, "_addr"},  {16'd0, oAddress},          {16'd0, nxt});
  endtask

  task automatic expect_bubble(input string tag, input logic [15:0] addr);
    chk({tag, "_valid"}, {31'd0, oInstructionValid}, 32'd0);
    chk({tag, "_instr"}, {4'd0, oInstruction},       {4'd0, NopInstr});
    chk({tag, "_addr"},  {16'd0, oAddress},          {16'd0, addr});
  endtask

  task automatic expect_reset(input string tag);
    expect_bubble(tag, 16'h0000);
    chk({tag, "_pc"}, {16'd0, oPC}, 32'd0);
  endtask

  initial begin
    Reset         = 1'b1;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = 16'd0;
    @(negedge Clock);

    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    expect_reset("reset");

    // Free run: oPC 0..3, address one ahead.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 16'd0, 1'b0);
      expect_valid("run", 16'(k));
    end

    // Stall three cycles at oPC=3: everything frozen.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 16'd0, 1'b1);
      expect_valid("stall", 16'd3);
    end
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("resume4", 16'd4);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("resume5", 16'd5);

    for (int k = 6; k <= 12; k++) begin
      cyc(1'b0, 1'b0, 16'd0, 1'b0);
      expect_valid("run2", 16'(k));
    end

    // Branch to 6 while oPC=12: one bubble, then 6, 7.
    cyc(1'b0, 1'b1, 16'd6, 1'b0);
    expect_bubble("br6_bubble", 16'd6);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("br6_tgt", 16'd6);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("br6_next", 16'd7);

    // Branch with stall: redirect wins.
    cyc(1'b0, 1'b1, 16'd2, 1'b1);
    expect_bubble("brst_bubble", 16'd2);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("brst_tgt", 16'd2);

    // PC wrap at 0xFFFF.
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
    expect_bubble("wrap_bubble", 16'hFFFF);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("wrap_ffff", 16'hFFFF);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("wrap_0000", 16'h0000);

    // Back-to-back branches: second target wins, another bubble.
    cyc(1'b0, 1'b1, 16'h0010, 1'b0);
    expect_bubble("b2b_first", 16'h0010);
    cyc(1'b0, 1'b1, 16'h0020, 1'b0);
    expect_bubble("b2b_second", 16'h0020);
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("b2b_tgt", 16'h0020);

    // Reset mid-stream beats branch and stall.
    cyc(1'b1, 1'b1, 16'h0030, 1'b1);
    expect_reset("midreset");
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    expect_valid("after_reset", 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the core's control path and the program ROM. Owns the program counter, drives the ROM address combinationally, and registers the returned 28-bit instruction into an instruction register for decode/execute. Handles decode back-pressure (stall) and control-flow redirects (BLE/JMP taken) by flushing one bubble. Presents each instruction with its own address so execute can compute relative targets.

## Interface
- ADDR_W, 16, program counter / ROM address width
- INSTR_W, 28, instruction width (opcode 4 bits + 24 bits operands)
- RESET_PC, 0, first address fetched after reset
- Clock  input  1  single system clock, all state on rising edge
- Reset  input  1  synchronous, active-high
- oAddress  output  ADDR_W  ROM address (equals PC), combinational from PC register
- iRomInstruction  input  INSTR_W  ROM data for oAddress, same cycle
- oInstruction  output  INSTR_W  instruction register to decode
- oInstructionValid  output  1  oInstruction is a real fetched instruction (not bubble)
- oPC  output  ADDR_W  address oInstruction was fetched from
- iStall  input  1  decode cannot accept; hold everything
- iBranchTaken  input  1  redirect request from execute, one-cycle pulse
- iBranchTarget  input  ADDR_W  redirect target, valid with iBranchTaken
- oFetchCount  output  16  valid instructions delivered (only with FETCH_PERF_COUNT_EN, else tied 0)

## Operation
- Registers: PC, IR, IR_PC, valid flag, state.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: entered on Reset. oAddress = RESET_PC; IR = {`NOP, 24'd0}, valid 0. Next edge (no stall): load IR from ROM, IR_PC = PC, PC = PC+1, valid 1, go RUN.
  - RUN: each edge with iStall=0: IR <= iRomInstruction, IR_PC <= PC, PC <= PC+1, valid 1.
  - FLUSH: entered when iBranchTaken=1 on an edge. That edge: PC <= iBranchTarget, IR <= NOP bubble, valid 0. Next edge: behaves as RUN from target, returns to RUN.
- Priority per edge: Reset > iBranchTaken > iStall > normal advance.
- iBranchTaken during iStall: redirect wins; stall ignored that edge.
- iStall=1 (no branch): PC, IR, IR_PC, valid, state all hold; oAddress stable.
- Back-to-back iBranchTaken (second in FLUSH): second target replaces first, another bubble.
- PC arithmetic modulo 2^ADDR_W: 0xFFFF + 1 -> 0x0000, no flag.
- Instruction content never decoded here; NOP/LED/BTN etc. pass through untouched.

## Timing
- Reset values: oAddress = RESET_PC, oInstruction = {`NOP, 24'd0}, oInstructionValid 0, oPC 0, oFetchCount 0, state BOOT.
- ROM is combinational: address-to-data zero cycles; fetch latency PC -> oInstruction one edge.
- Sustained throughput one instruction per cycle when iStall=0.
- Taken branch cost: exactly one bubble cycle (valid 0) before target instruction appears.
- Reset asserted mid-stream: next edge returns to reset values regardless of stall/branch.

## Configuration
- FETCH_PERF_COUNT_EN defined: oFetchCount increments on every edge where a valid instruction is loaded into IR (valid goes/stays 1 with new load); saturates at 0xFFFF; cleared by Reset; holds during stall and bubbles.
- Not defined: counter logic absent, oFetchCount constant 16'd0.

## Test plan
- Reset then 5 free-running cycles with ROM content = address -> oPC/oInstruction 0,1,2,3,4, valid 1 from cycle 2; oAddress leads oPC by 1.
- iStall high 3 cycles while oPC=3 -> oPC, oInstruction, oAddress=4 frozen 3 cycles, then 4,5 resume with no loss or duplicate.
- iBranchTaken with target 6 while oPC=12 -> next cycle valid 0 with NOP; following cycle oPC=6; then 7.
- iBranchTaken and iStall together, target 2 -> redirect taken, bubble, then oPC=2.
- PC preset via branch to 0xFFFF, run 2 cycles -> oPC 0xFFFF then 0x0000, valid stays 1.
- FETCH_PERF_COUNT_EN: 10 advances, 1 branch bubble, 2 stall cycles -> oFetchCount = 10; Reset mid-run -> 0 next edge.
